// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle between a pattern source and seq_pattern_tx.
interface seq_pattern_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] pattern;
    logic [3:0]       rpt;
    logic             seq_out;
    logic             frame;
    logic             busy;
    logic             done;

    // Requester side: issues start/stop and the pattern, observes the serial stream.
    modport master (
        output start, stop, pattern, rpt,
        input  seq_out, frame, busy, done
    );

    // Transmitter side.
    modport slave (
        input  start, stop, pattern, rpt,
        output seq_out, frame, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and sends it
// MSB-first rpt+1 times, with GAP_CYCLES idle cycles between frames.
module seq_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_tx_if.slave  bus
);
    localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    bitcnt_q;
    logic [3:0]       rptcnt_q;
    logic [GW-1:0]    gapcnt_q;
    logic             done_q;

    logic             accept_c;
    logic             last_bit_c;
    logic             last_frame_c;
    logic             gap_last_c;

    assign accept_c     = (state_q == IDLE) && bus.start && !bus.stop;
    assign last_bit_c   = (bitcnt_q == BW'(WIDTH - 1));
    assign last_frame_c = (rptcnt_q == 4'd0);
    assign gap_last_c   = (gapcnt_q == GW'(GAP_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; stop overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_bit_c) begin
                    if (last_frame_c) begin
                        state_d = IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_last_c) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.stop) begin
            state_d = IDLE;
        end
    end

    // Output decode: only SEND drives pattern bits; IDLE and GAP hold the line low.
    always_comb begin
        bus.seq_out = 1'b0;
        bus.frame   = 1'b0;
        bus.busy    = (state_q != IDLE);
        if (state_q == SEND) begin
            bus.seq_out = sh_q[WIDTH-1];
            bus.frame   = 1'b1;
        end
    end

    assign bus.done = done_q;

    // Datapath: pattern latch, shifter, bit/repeat/gap counters and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q    <= '0;
            sh_q     <= '0;
            bitcnt_q <= '0;
            rptcnt_q <= '0;
            gapcnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        pat_q    <= bus.pattern;
                        sh_q     <= bus.pattern;
                        rptcnt_q <= bus.rpt;
                        bitcnt_q <= '0;
                    end
                end
                SEND: begin
                    sh_q     <= sh_q << 1;
                    bitcnt_q <= bitcnt_q + BW'(1);
                    if (last_bit_c) begin
                        if (last_frame_c) begin
                            done_q <= !bus.stop;
                        end else begin
                            rptcnt_q <= rptcnt_q - 4'd1;
                            if (GAP_CYCLES == 0) begin
                                sh_q     <= pat_q;
                                bitcnt_q <= '0;
                            end else begin
                                gapcnt_q <= '0;
                            end
                        end
                    end
                end
                GAP: begin
                    gapcnt_q <= gapcnt_q + GW'(1);
                    if (gap_last_c) begin
                        sh_q     <= pat_q;
                        bitcnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with a 2-cycle gap, one back-to-back.
module tb_seq_pattern_tx;
    logic clk;
    logic reset;

    int total;
    int passed;
    int fails;

    logic [3:0] obs;

    seq_pattern_tx_if #(.WIDTH(8)) if2 ();
    seq_pattern_tx_if #(.WIDTH(8)) if0 ();

    seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed vector is {seq_out, frame, busy, done}.
    task automatic sample(input bit sel, output logic [3:0] o);
        if (sel) o = {if2.seq_out, if2.frame, if2.busy, if2.done};
        else     o = {if0.seq_out, if0.frame, if0.busy, if0.done};
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Checks one full frame of 8 bits starting in the current cycle; ends one cycle later.
    task automatic check_frame(input bit sel, input logic [7:0] pat, input string tag);
        for (int k = 7; k >= 0; k--) begin
            sample(sel, obs);
            chk(tag, 32'(obs), 32'({pat[k], 1'b1, 1'b1, 1'b0}));
            tick();
        end
    endtask

    initial begin
        logic [7:0] exp_pat;
        logic       any_act;
        total  = 0;
        passed = 0;
        fails  = 0;
        reset  = 1'b0;
        if2.start = 1'b0; if2.stop = 1'b0; if2.pattern = '0; if2.rpt = '0;
        if0.start = 1'b0; if0.stop = 1'b0; if0.pattern = '0; if0.rpt = '0;

        // Reset state.
        #3;
        sample(1'b1, obs); chk("reset_gap2", 32'(obs), 32'h0);
        sample(1'b0, obs); chk("reset_gap0", 32'(obs), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single frame 1011_0010, rpt=0.
        if2.pattern = 8'b1011_0010; if2.rpt = 4'd0; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        check_frame(1'b1, 8'b1011_0010, "t1_bit");
        sample(1'b1, obs); chk("t1_done", 32'(obs), 32'b0001);
        tick();
        sample(1'b1, obs); chk("t1_idle", 32'(obs), 32'b0000);

        // Repeat with gap: A5 twice, two idle cycles between.
        if2.pattern = 8'hA5; if2.rpt = 4'd1; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        check_frame(1'b1, 8'hA5, "t2_f1");
        sample(1'b1, obs); chk("t2_gap9", 32'(obs), 32'b0010);
        tick();
        sample(1'b1, obs); chk("t2_gap10", 32'(obs), 32'b0010);
        tick();
        check_frame(1'b1, 8'hA5, "t2_f2");
        sample(1'b1, obs); chk("t2_done19", 32'(obs), 32'b0001);
        tick();
        sample(1'b1, obs); chk("t2_idle20", 32'(obs), 32'b0000);

        // Back-to-back F0 x3, then a new start in the done cycle.
        if0.pattern = 8'hF0; if0.rpt = 4'd2; if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check_frame(1'b0, 8'hF0, "t3_f1");
        check_frame(1'b0, 8'hF0, "t3_f2");
        check_frame(1'b0, 8'hF0, "t3_f3");
        sample(1'b0, obs); chk("t3_done25", 32'(obs), 32'b0001);
        if0.pattern = 8'h81; if0.rpt = 4'd0; if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check_frame(1'b0, 8'h81, "t3_next");
        sample(1'b0, obs); chk("t3_done34", 32'(obs), 32'b0001);
        tick();

        // Start/pattern/rpt changes while busy are ignored.
        if2.pattern = 8'h3C; if2.rpt = 4'd0; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        exp_pat = 8'h3C;
        for (int c = 1; c <= 8; c++) begin
            sample(1'b1, obs);
            chk("t4_bit", 32'(obs), 32'({exp_pat[8-c], 1'b1, 1'b1, 1'b0}));
            if (c == 3) begin
                if2.start = 1'b1; if2.pattern = 8'h00; if2.rpt = 4'hF;
            end
            if (c == 5) if2.start = 1'b0;
            tick();
        end
        sample(1'b1, obs); chk("t4_done", 32'(obs), 32'b0001);
        tick();
        sample(1'b1, obs); chk("t4_idle", 32'(obs), 32'b0000);

        // Abort: stop sampled at the end of cycle 4 of an FF frame.
        if2.pattern = 8'hFF; if2.rpt = 4'd3; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample(1'b1, obs);
            chk("t5_bit", 32'(obs), 32'b1110);
            if (c == 4) if2.stop = 1'b1;
            tick();
        end
        sample(1'b1, obs); chk("t5_abort", 32'(obs), 32'b0000);
        if2.stop = 1'b0;
        any_act = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            any_act = any_act | if2.seq_out | if2.busy | if2.done;
        end
        chk("t5_quiet", 32'(any_act), 32'h0);
        // Stop wins over start in IDLE.
        if2.start = 1'b1; if2.stop = 1'b1;
        tick();
        sample(1'b1, obs); chk("t5_stop_prio", 32'(obs), 32'b0000);
        if2.start = 1'b0; if2.stop = 1'b0;
        tick();

        // Asynchronous reset in the middle of a gap.
        if2.pattern = 8'hA5; if2.rpt = 4'd1; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        sample(1'b1, obs); chk("t6_in_gap", 32'(obs), 32'b0010);
        #2;
        reset = 1'b0;
        #1;
        sample(1'b1, obs); chk("t6_async", 32'(obs), 32'b0000);
        tick();
        sample(1'b1, obs); chk("t6_held", 32'(obs), 32'b0000);
        @(negedge clk);
        reset = 1'b1;
        tick();
        sample(1'b1, obs); chk("t6_post_rst", 32'(obs), 32'b0000);
        if2.pattern = 8'h80; if2.rpt = 4'd0; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        check_frame(1'b1, 8'h80, "t6_recover");
        sample(1'b1, obs); chk("t6_done", 32'(obs), 32'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
